dcache_nway: RTL
================

# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache between the pipeline memory stage and the memory arbiter. It generalises the fixed two-way/two-word dcache to configurable ways, sets and block size, with true-LRU replacement across any way count. It provides a halt-triggered flush that writes back every dirty word and invalidates the array. Hits complete in the request cycle; misses stall the pipeline through `dhit` low.

## Interface
- `WAYS`, 2: associativity; power of two, 1..8.
- `SETS`, 8: sets; power of two, 2..64.
- `BLK_WORDS`, 2: 32-bit words per block; power of two, 1..8.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset; asynchronous, active-high.
- `halt` in 1: pipeline halted; starts flush, level-sensitive.
- `dmemREN` in 1: load request.
- `dmemWEN` in 1: store request; wins if asserted with `dmemREN`.
- `dmemaddr` in 32: byte address; [1:0] ignored.
- `dmemstore` in 32: store data.
- `dhit` out 1: request serviced this cycle.
- `dmemload` out 32: load data, valid while `dhit` is high.
- `flushed` out 1: flush complete; sticky until reset.
- `dREN` out 1: memory read request.
- `dWEN` out 1: memory write request.
- `daddr` out 32: memory word address, [1:0]=00.
- `dstore` out 32: memory write data.
- `dload` in 32: memory read data.
- `dwait` in 1: memory busy; a word transfer completes in the cycle `dwait`=0 while a request is held.

## Operation
- Address split: offset bits [OB+1:2] with OB=log2(BLK_WORDS), index bits [IB+OB+1:OB+2] with IB=log2(SETS), tag = remaining upper bits.
- Line state: valid, dirty, tag, BLK_WORDS data words. Each set also holds a per-way LRU age of log2(WAYS) bits; age 0 is most recent.
- Hit: valid way with a matching tag in IDLE. `dhit`=1 combinationally.
  - Load: `dmemload` = selected word.
  - Store: word written and dirty set at the edge.
- LRU update on every hit: the accessed way goes to age 0; ways younger than its old age increment; all others are unchanged.
- Victim on miss: the lowest-index invalid way; otherwise the way with age WAYS-1.
- FSM states: IDLE, WB, LOAD, FLUSH, FLUSH_WB, DONE.
  - IDLE, miss, dirty victim → WB. IDLE, miss, clean victim → LOAD.
  - WB: `dWEN`=1. `daddr` = {victim tag, index, word cnt, 00}. `dstore` = victim word. The word counter advances on each `dwait`=0. After the last word, clear dirty and go to LOAD.
  - LOAD: `dREN`=1. `daddr` = {req tag, index, cnt, 00}. Each `dwait`=0 writes `dload` into the victim word. After the last word, set valid, clear dirty, write tag, and return to IDLE. The retried request then hits; a store also writes and sets dirty on that hit.
  - IDLE with `halt`=1 → FLUSH. `halt` has priority over a new request; a miss already in WB/LOAD finishes first.
  - FLUSH scans (set, way) in order: set-major, way-minor, starting from set 0/way 0. Dirty and valid line → FLUSH_WB (writes BLK_WORDS words like WB, then clears dirty and returns to FLUSH). Every scanned line is invalidated. After the last line → DONE.
  - DONE: `flushed`=1, no memory requests, `dhit`=0. Terminal state.
- Reset: FSM to IDLE, all valid/dirty cleared, ages for way w set to w, counters cleared. All outputs 0.

## Timing
- Hit latency 0 cycles; the store commits at the same edge.
- Clean miss: BLK_WORDS×(memory latency) cycles in LOAD, plus 1 cycle back in IDLE for the hit.
- Dirty miss: adds BLK_WORDS transfers in WB, before LOAD.
- `dREN`/`dWEN` are decoded from state. They are never both high, and they stay high until their transfer completes.
- `dhit`=0 in every state except IDLE-hit.
- `RST` mid-transaction: all outputs drop asynchronously; the partial line is discarded.

## Test plan
- Cold load, WAYS=2/SETS=8/BLK_WORDS=2, mem latency 2: read 0x40 → `dREN` at 0x40 then 0x44, then `dhit`=1 with `dmemload`=mem[0x40]; no `dWEN`.
- Store hit: write 0xDEADBEEF to 0x44, then read 0x44 → `dhit` in the request cycle both times, `dmemload`=0xDEADBEEF, zero memory requests.
- LRU: read 0x40, 0x80 (set 0 full), read 0x40, read 0xC0 → the 0x80 line is evicted clean. A following read of 0x40 hits; 0x80 misses.
- Dirty eviction: write 0x80=0x11111111, touch 0x40, read 0xC0 → `dWEN` at 0x80/0x84 (`dstore` 0x11111111, then the old word), then `dREN` at 0xC0/0xC4.
- Flush: dirty lines at 0x40, 0x80, 0x48; assert `halt` → 6 `dWEN` transfers in order 0x40, 0x44, 0x80, 0x84, 0x48, 0x4C, then `flushed`=1 and held; reads are not serviced.
- Reset mid-LOAD: pulse `RST` while `dREN`=1 → `dREN` goes 0 immediately, `flushed`=0, and the next read of the same address misses.

Source files
------------

// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement and a halt-triggered flush of all dirty lines.
module dcache_nway #(
    parameter int unsigned WAYS      = 2,
    parameter int unsigned SETS      = 8,
    parameter int unsigned BLK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int unsigned OB  = $clog2(BLK_WORDS);
    localparam int unsigned IB  = $clog2(SETS);
    localparam int unsigned AB  = $clog2(WAYS);
    localparam int unsigned OBW = (OB > 0) ? OB : 1;
    localparam int unsigned AW  = (AB > 0) ? AB : 1;
    localparam int unsigned TW  = 30 - OB - IB;

    typedef enum logic [2:0] {IDLE, WB, LOAD, FLUSH, FLUSH_WB, DONE} state_t;

    state_t state_q, state_d;
    logic [OBW-1:0] cnt;
    logic [AW-1:0]  vway, fway;
    logic [IB-1:0]  fset;

    logic          valid_q [SETS][WAYS];
    logic          dirty_q [SETS][WAYS];
    logic [AW-1:0] age_q   [SETS][WAYS];
    logic [TW-1:0] tag_q   [SETS][WAYS];
    logic [31:0]   data_q  [SETS][WAYS][BLK_WORDS];

    logic [29:0]    waddr;
    logic [OBW-1:0] off;
    logic [IB-1:0]  idx;
    logic [TW-1:0]  tag;
    logic           req, hit, found, last, xfer, flush_last, flush_dirty;
    logic [AW-1:0]  hit_way, victim;
    logic           unused_bits;

    assign waddr       = dmemaddr[31:2];
    assign off         = OBW'(waddr & 30'(BLK_WORDS - 1));
    assign idx         = IB'(waddr >> OB);
    assign tag         = TW'(waddr >> (OB + IB));
    assign req         = dmemREN | dmemWEN;
    assign last        = (cnt == OBW'(BLK_WORDS - 1));
    assign xfer        = ~dwait;
    assign flush_last  = (fset == IB'(SETS - 1)) && (fway == AW'(WAYS - 1));
    assign flush_dirty = valid_q[fset][fway] && dirty_q[fset][fway];
    assign unused_bits = ^dmemaddr[1:0];

    function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [IB-1:0] i,
                                            input logic [OBW-1:0] c);
        return (32'(t) << (IB + OB + 2)) | (32'(i) << (OB + 2)) | (32'(c) << 2);
    endfunction

    // Tag match and victim choice: first invalid way, else the oldest way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        found   = 1'b0;
        victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag && !hit) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!valid_q[idx][w] && !found) begin
                found  = 1'b1;
                victim = AW'(w);
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == AW'(WAYS - 1)) victim = AW'(w);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dhit     = 1'b0;
        dmemload = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        flushed  = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                end else if (req) begin
                    if (hit) begin
                        dhit     = 1'b1;
                        dmemload = data_q[idx][hit_way][off];
                    end else begin
                        state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? WB : LOAD;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(tag_q[idx][vway], idx, cnt);
                dstore = data_q[idx][vway][cnt];
                if (xfer && last) state_d = LOAD;
            end
            LOAD: begin
                dREN  = 1'b1;
                daddr = mk_addr(tag, idx, cnt);
                if (xfer && last) state_d = IDLE;
            end
            FLUSH: begin
                if (flush_dirty)     state_d = FLUSH_WB;
                else if (flush_last) state_d = DONE;
            end
            FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(tag_q[fset][fway], fset, cnt);
                dstore = data_q[fset][fway][cnt];
                if (xfer && last) state_d = FLUSH;
            end
            DONE:    flushed = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // Control state, line status bits and LRU ages.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt     <= '0;
            vway    <= '0;
            fset    <= '0;
            fway    <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AW'(w);
                end
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (!halt && req) begin
                        if (hit) begin
                            for (int w = 0; w < WAYS; w++) begin
                                if (AW'(w) == hit_way)
                                    age_q[idx][w] <= '0;
                                else if (age_q[idx][w] < age_q[idx][hit_way])
                                    age_q[idx][w] <= age_q[idx][w] + AW'(1);
                            end
                            if (dmemWEN) dirty_q[idx][hit_way] <= 1'b1;
                        end else begin
                            vway <= victim;
                            cnt  <= '0;
                        end
                    end
                end
                WB, FLUSH_WB: begin
                    if (xfer) begin
                        cnt <= last ? '0 : cnt + OBW'(1);
                        if (last && state_q == WB)       dirty_q[idx][vway]  <= 1'b0;
                        if (last && state_q == FLUSH_WB) dirty_q[fset][fway] <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        cnt <= last ? '0 : cnt + OBW'(1);
                        if (last) begin
                            valid_q[idx][vway] <= 1'b1;
                            dirty_q[idx][vway] <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_dirty) begin
                        cnt <= '0;
                    end else begin
                        valid_q[fset][fway] <= 1'b0;
                        dirty_q[fset][fway] <= 1'b0;
                        if (fway == AW'(WAYS - 1)) begin
                            fway <= '0;
                            fset <= fset + IB'(1);
                        end else begin
                            fway <= fway + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and tag arrays carry no reset; validity guards their contents.
    always_ff @(posedge CLK) begin
        if (state_q == IDLE && !halt && dmemWEN && hit)
            data_q[idx][hit_way][off] <= dmemstore;
        if (state_q == LOAD && xfer) begin
            data_q[idx][vway][cnt] <= dload;
            if (last) tag_q[idx][vway] <= tag;
        end
    end
endmodule
